// File: rtl/asm_pkg.sv
// Shared definitions for the program assembler: opcodes, calculator key codes,
// FSM state encoding and the key-code to ALU-opcode decoder.
package asm_pkg;

  localparam logic [3:0] OPC_BRA  = 4'd0;
  localparam logic [3:0] OPC_LD_A = 4'd1;
  localparam logic [3:0] OPC_LD_B = 4'd2;
  localparam logic [3:0] OPC_STR  = 4'd3;
  localparam logic [3:0] OPC_ADD  = 4'd4;
  localparam logic [3:0] OPC_SUB  = 4'd5;
  localparam logic [3:0] OPC_MUL  = 4'd6;
  localparam logic [3:0] OPC_DIV  = 4'd7;
  localparam logic [3:0] OPC_HLT  = 4'd8;
  localparam logic [3:0] OPC_OR   = 4'd9;
  localparam logic [3:0] OPC_AND  = 4'd10;

  localparam logic [7:0] KEY_ADD = 8'd20;
  localparam logic [7:0] KEY_SUB = 8'd21;
  localparam logic [7:0] KEY_MUL = 8'd22;
  localparam logic [7:0] KEY_DIV = 8'd23;
  localparam logic [7:0] KEY_AND = 8'd24;
  localparam logic [7:0] KEY_OR  = 8'd25;

  typedef enum logic [2:0] {IDLE, EMIT, DATA, CLR, FIN} state_t;

  typedef struct packed {
    logic       legal;
    logic [3:0] opc;
  } key_dec_t;

  function automatic key_dec_t key_to_opcode(input logic [7:0] key);
    key_dec_t d;
    d.legal = 1'b1;
    d.opc   = OPC_HLT;
    case (key)
      KEY_ADD: d.opc = OPC_ADD;
      KEY_SUB: d.opc = OPC_SUB;
      KEY_MUL: d.opc = OPC_MUL;
      KEY_DIV: d.opc = OPC_DIV;
      KEY_AND: d.opc = OPC_AND;
      KEY_OR:  d.opc = OPC_OR;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/asm_word_rom.sv
// Combinational lookup of the RAM address and word written in each
// program/data/clear step of the assembler sequence.
module asm_word_rom
  import asm_pkg::*;
#(
  parameter int OPC_W     = 4,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8,
  parameter int PROG_BASE = 0,
  parameter int OP_A_ADDR = 9,
  parameter int OP_B_ADDR = 10,
  parameter int RES_ADDR  = 15
) (
  input  state_t                  state,
  input  logic [2:0]              idx,
  input  logic [OPC_W-1:0]        alu_opcode,
  input  logic [DATA_W-1:0]       operand_a,
  input  logic [DATA_W-1:0]       operand_b,
  output logic [ADDR_W-1:0]       addr,
  output logic [OPC_W+ADDR_W-1:0] word
);

  localparam int IW = OPC_W + ADDR_W;

  function automatic logic [IW-1:0] instr(input logic [OPC_W-1:0] opc,
                                          input logic [ADDR_W-1:0] fld);
    return {opc, fld};
  endfunction

  always_comb begin
    addr = '0;
    word = '0;
    case (state)
      EMIT: begin
        // Program addresses wrap naturally in the ADDR_W-bit adder.
        addr = ADDR_W'(PROG_BASE) + ADDR_W'(idx);
        case (idx)
          3'd0:    word = instr(OPC_W'(OPC_LD_A), ADDR_W'(OP_A_ADDR));
          3'd1:    word = instr(OPC_W'(OPC_LD_B), ADDR_W'(OP_B_ADDR));
          3'd2:    word = instr(alu_opcode, '0);
          3'd3:    word = instr(OPC_W'(OPC_STR), ADDR_W'(RES_ADDR));
          default: word = instr(OPC_W'(OPC_HLT), '0);
        endcase
      end
      DATA: begin
        if (idx == 3'd0) begin
          addr = ADDR_W'(OP_A_ADDR);
          word = IW'(operand_a);
        end else begin
          addr = ADDR_W'(OP_B_ADDR);
          word = IW'(operand_b);
        end
      end
      CLR: begin
        addr = ADDR_W'(RES_ADDR);
        word = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/program_assembler.sv
// Writes a five-instruction program plus two operand words into the shared RAM
// for one calculator operation. Define ASM_CLEAR_RESULT_EN to also zero the result word.
module program_assembler
  import asm_pkg::*;
#(
  parameter int OPC_W     = 4,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8,
  parameter int PROG_BASE = 0,
  parameter int OP_A_ADDR = 9,
  parameter int OP_B_ADDR = 10,
  parameter int RES_ADDR  = 15
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [DATA_W-1:0]       operand_1,
  input  logic [DATA_W-1:0]       operand_2,
  input  logic [7:0]              operator,
  input  logic                    mem_ready,
  output logic                    mem_wr_en,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [OPC_W+ADDR_W-1:0] mem_wr_data,
  output logic [OPC_W-1:0]        alu_opcode,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  state_t                  state, state_n;
  logic [2:0]              idx, idx_n;
  logic [OPC_W-1:0]        opc_n;
  logic [DATA_W-1:0]       opa, opb, opa_n, opb_n;
  logic                    err_n;
  logic                    wr_done;
  key_dec_t                dec;
  logic [ADDR_W-1:0]       rom_addr;
  logic [OPC_W+ADDR_W-1:0] rom_word;

  assign wr_done = mem_wr_en & mem_ready;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    opc_n   = alu_opcode;
    opa_n   = opa;
    opb_n   = opb;
    err_n   = 1'b0;
    dec     = key_to_opcode(operator);
    case (state)
      IDLE: begin
        if (start) begin
          if (dec.legal) begin
            opc_n   = OPC_W'(dec.opc);
            opa_n   = operand_1;
            opb_n   = operand_2;
            idx_n   = '0;
            state_n = EMIT;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      EMIT: begin
        if (wr_done) begin
          if (idx == 3'd4) begin
            idx_n   = '0;
            state_n = DATA;
          end else begin
            idx_n = idx + 3'd1;
          end
        end
      end
      DATA: begin
        if (wr_done) begin
          if (idx == 3'd1) begin
            idx_n = '0;
`ifdef ASM_CLEAR_RESULT_EN
            state_n = CLR;
`else
            state_n = FIN;
`endif
          end else begin
            idx_n = idx + 3'd1;
          end
        end
      end
      CLR: begin
        if (wr_done) state_n = FIN;
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Look up the word for the step being entered so every output is a register.
  asm_word_rom #(
    .OPC_W(OPC_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PROG_BASE(PROG_BASE),
    .OP_A_ADDR(OP_A_ADDR), .OP_B_ADDR(OP_B_ADDR), .RES_ADDR(RES_ADDR)
  ) u_rom (
    .state     (state_n),
    .idx       (idx_n),
    .alu_opcode(opc_n),
    .operand_a (opa_n),
    .operand_b (opb_n),
    .addr      (rom_addr),
    .word      (rom_word)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      idx         <= '0;
      alu_opcode  <= '0;
      mem_wr_en   <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      alu_opcode  <= opc_n;
      mem_wr_en   <= (state_n == EMIT) || (state_n == DATA) || (state_n == CLR);
      mem_addr    <= rom_addr;
      mem_wr_data <= rom_word;
      busy        <= (state_n != IDLE);
      done        <= (state_n == FIN);
      error       <= err_n;
    end
  end

  always_ff @(posedge clock) begin
    opa <= opa_n;
    opb <= opb_n;
  end

endmodule
